// File: rtl/dct8_odd_acc.sv
// Odd-part accumulator of the 8-point DCT-II: folds four product sets
// (18/50/75/89 * o_k) into y1, y3, y5, y7 behind a registered valid/ready output.
module dct8_odd_acc #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 29
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  x18,
    input  logic signed [IN_W-1:0]  x50,
    input  logic signed [IN_W-1:0]  x75,
    input  logic signed [IN_W-1:0]  x89,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y1,
    output logic signed [OUT_W-1:0] y3,
    output logic signed [OUT_W-1:0] y5,
    output logic signed [OUT_W-1:0] y7
);

    localparam int EXT = OUT_W - IN_W;

    logic [1:0]              k_q, k_d;
    logic                    vld_q, vld_d;
    logic signed [OUT_W-1:0] acc_q [4];
    logic signed [OUT_W-1:0] acc_d [4];
    logic signed [OUT_W-1:0] y_q   [4];
    logic signed [OUT_W-1:0] y_d   [4];
    logic signed [OUT_W-1:0] term  [4];
    logic signed [OUT_W-1:0] base  [4];
    logic signed [OUT_W-1:0] sum   [4];
    logic [3:0]              neg;
    logic signed [OUT_W-1:0] e18, e50, e75, e89;
    logic                    fire;

    assign e18 = {{EXT{x18[IN_W-1]}}, x18};
    assign e50 = {{EXT{x50[IN_W-1]}}, x50};
    assign e75 = {{EXT{x75[IN_W-1]}}, x75};
    assign e89 = {{EXT{x89[IN_W-1]}}, x89};

    // The last beat may only land once the held result has gone or is leaving.
    assign in_ready  = (k_q != 2'd3) || !vld_q || out_ready;
    assign fire      = in_valid && in_ready;
    assign out_valid = vld_q;
    assign y1        = y_q[0];
    assign y3        = y_q[1];
    assign y5        = y_q[2];
    assign y7        = y_q[3];

    // Column k of the odd-part coefficient matrix; neg bit i subtracts term i.
    always_comb begin
        term = '{e89, e75, e50, e18};
        neg  = 4'b0000;
        unique case (k_q)
            2'd0: begin
                term = '{e89, e75, e50, e18};
                neg  = 4'b0000;
            end
            2'd1: begin
                term = '{e75, e18, e89, e50};
                neg  = 4'b1110;
            end
            2'd2: begin
                term = '{e50, e89, e18, e75};
                neg  = 4'b0010;
            end
            2'd3: begin
                term = '{e18, e50, e75, e89};
                neg  = 4'b1010;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            base[i] = (k_q == 2'd0) ? '0 : acc_q[i];
            sum[i]  = neg[i] ? base[i] - term[i] : base[i] + term[i];
        end
    end

    always_comb begin
        k_d   = k_q;
        vld_d = vld_q;
        acc_d = acc_q;
        y_d   = y_q;
        if (vld_q && out_ready)
            vld_d = 1'b0;
        if (fire) begin
            k_d   = k_q + 2'd1;
            acc_d = sum;
            if (k_q == 2'd3) begin
                y_d   = sum;
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= 2'd0;
            vld_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                y_q[i]   <= '0;
            end
        end else begin
            k_q   <= k_d;
            vld_q <= vld_d;
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

endmodule

// File: tb/tb_dct8_odd_acc.sv
// Self-checking bench for dct8_odd_acc against a matrix-product reference
// of the DCT-II odd part.
module tb_dct8_odd_acc;

    localparam int IN_W  = 27;
    localparam int OUT_W = 29;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    logic signed [IN_W-1:0] x18, x50, x75, x89;
    logic out_valid;
    logic out_ready;
    logic signed [OUT_W-1:0] y1, y3, y5, y7;

    int errors = 0;
    int checks = 0;

    dct8_odd_acc #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x18(x18), .x50(x50), .x75(x75), .x89(x89),
        .out_valid(out_valid), .out_ready(out_ready),
        .y1(y1), .y3(y3), .y5(y5), .y7(y7)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic longint ref_y(input int j, input int o [4]);
        int c [4][4];
        longint s;
        c = '{'{89, 75, 50, 18}, '{75, -18, -89, -50},
              '{50, -89, 18, 75}, '{18, -50, 75, -89}};
        s = 0;
        for (int k = 0; k < 4; k++)
            s += longint'(c[j][k]) * longint'(o[k]);
        return s;
    endfunction

    function automatic longint get_y(input int j);
        case (j)
            0: return longint'(y1);
            1: return longint'(y3);
            2: return longint'(y5);
            default: return longint'(y7);
        endcase
    endfunction

    task automatic set_prod(input int o);
        x18 = IN_W'(18 * o);
        x50 = IN_W'(50 * o);
        x75 = IN_W'(75 * o);
        x89 = IN_W'(89 * o);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic push(input int o);
        int n;
        set_prod(o);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_row(input int o [4]);
        for (int k = 0; k < 4; k++) push(o[k]);
    endtask

    task automatic drain;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_prod(0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (get_y(j) !== 0) begin
                errors++;
                $display("FAIL reset_y%0d got %0d required 0", 2*j+1, get_y(j));
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_row_check(input string name, input int o [4]);
        out_ready = 1'b1;
        push_row(o);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid out_valid=%b required 1", name, out_valid);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (get_y(j) !== ref_y(j, o)) begin
                errors++;
                $display("FAIL %s_y%0d got %0d required %0d", name, 2*j+1, get_y(j), ref_y(j, o));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear out_valid=%b required 0", name, out_valid);
        end
    endtask

    task automatic test_impulse;
        int o [4] = '{1, 0, 0, 0};
        run_row_check("impulse", o);
    endtask

    task automatic test_all_ones;
        int o [4] = '{1, 1, 1, 1};
        run_row_check("ones", o);
    endtask

    task automatic test_neg_last;
        int o [4] = '{0, 0, 0, -1};
        run_row_check("neglast", o);
        o[3] = -262144;
        run_row_check("negext", o);
        checks++;
        if (ref_y(0, o) !== -64'sd4718592) begin
            errors++;
            $display("FAIL negext_model got %0d required -4718592", ref_y(0, o));
        end
    endtask

    task automatic test_backpressure;
        int a [4] = '{3, -7, 11, 2};
        int b [4] = '{-5, 9, 1, -4};
        out_ready = 1'b0;
        push_row(a);
        for (int k = 0; k < 3; k++) push(b[k]);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_valid out_valid=%b required 1", out_valid);
        end
        set_prod(b[3]);
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low2 in_ready=%b required 0", in_ready);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (get_y(j) !== ref_y(j, a)) begin
                errors++;
                $display("FAIL bp_stable_y%0d got %0d required %0d", 2*j+1, get_y(j), ref_y(j, a));
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_valid out_valid=%b required 1", out_valid);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (get_y(j) !== ref_y(j, b)) begin
                errors++;
                $display("FAIL bp_second_y%0d got %0d required %0d", 2*j+1, get_y(j), ref_y(j, b));
            end
        end
        drain();
    endtask

    task automatic test_bubbles;
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int o [4] = '{1, 1, 1, 1};
        int cnt = 0;
        bit took;
        out_ready = 1'b1;
        set_prod(1);
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            #1;
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) cnt++;
            checks++;
            if (out_valid !== (took && cnt == 4)) begin
                errors++;
                $display("FAIL bubble_valid_c%0d out_valid=%b required %b", i, out_valid, took && cnt == 4);
            end
        end
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (get_y(j) !== ref_y(j, o)) begin
                errors++;
                $display("FAIL bubble_y%0d got %0d required %0d", 2*j+1, get_y(j), ref_y(j, o));
            end
        end
        drain();
    endtask

    task automatic test_reset_mid;
        int a [4] = '{4, 4, -4, 4};
        int imp [4] = '{1, 0, 0, 0};
        out_ready = 1'b0;
        push_row(a);
        push(7);
        push(-3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_flags out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (get_y(j) !== 0) begin
                errors++;
                $display("FAIL midrst_y%0d got %0d required 0", 2*j+1, get_y(j));
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_row_check("midrst_row", imp);
    endtask

    task automatic test_random;
        int o [4];
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 4; k++)
                o[k] = int'($urandom_range(524288, 0)) - 262144;
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(2, 0)) begin
                    @(posedge clk); #1;
                end
                push(o[k]);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_valid out_valid=%b required 1", r, out_valid);
            end
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (get_y(j) !== ref_y(j, o)) begin
                    errors++;
                    $display("FAIL rand%0d_y%0d got %0d required %0d", r, 2*j+1, get_y(j), ref_y(j, o));
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_all_ones();
        test_neg_last();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
